// File: rtl/sync_frame_tx.sv
// sync_frame_tx: serial frame transmitter for the single-bit sync link.
// On an accepted start it sends SYNC_CODE (bit 0 first), then the latched
// payload (LSB first), one bit per clock. It then idles the line for
// GAP_CYCLES cycles before it accepts the next request.
//
// Ports
//   clk_i        system clock, all state changes on posedge
//   rst_ni       asynchronous active-low reset
//   start_i      frame request, honoured only while ready_o=1
//   payload_i    frame data, captured on the accepting edge
//   ready_o      high only in IDLE
//   tx_data_o    serial bit, 0 whenever tx_valid_o=0
//   tx_valid_o   high while a sync or payload bit is on tx_data_o
//   done_o       one-cycle pulse after the last payload bit
module sync_frame_tx #(
  parameter int unsigned                SYNC_WIDTH    = 4,
  parameter logic [SYNC_WIDTH-1:0]      SYNC_CODE     = 4'b1001,
  parameter int unsigned                PAYLOAD_WIDTH = 8,
  parameter int unsigned                GAP_CYCLES    = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic [PAYLOAD_WIDTH-1:0] payload_i,
  output logic                     ready_o,
  output logic                     tx_data_o,
  output logic                     tx_valid_o,
  output logic                     done_o
);

  // Counter must index the longest phase; floor of 2 keeps it at least 1 bit.
  localparam int unsigned MAX_SP  = (SYNC_WIDTH > PAYLOAD_WIDTH) ? SYNC_WIDTH : PAYLOAD_WIDTH;
  localparam int unsigned MAX_SPG = (MAX_SP > GAP_CYCLES) ? MAX_SP : GAP_CYCLES;
  localparam int unsigned CNT_MAX = (MAX_SPG > 2) ? MAX_SPG : 2;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);

  // Last count value of each phase; GAP_LAST is only used when GAP_CYCLES>0.
  localparam int unsigned GAP_LAST_I = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_WIDTH - 1);
  localparam logic [CNT_W-1:0] PAY_LAST  = CNT_W'(PAYLOAD_WIDTH - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_LAST_I);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SYNC    = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_GAP     = 2'd3
  } state_e;

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [PAYLOAD_WIDTH-1:0] shift_q, shift_d;
  logic                     ready_q, ready_d;
  logic                     tx_data_q, tx_data_d;
  logic                     tx_valid_q, tx_valid_d;
  logic                     done_q, done_d;

  logic [CNT_W-1:0]         cnt_inc;
  logic                     sync_bit;
  logic                     pay_bit;

  // Bit that goes out on the next cycle when the counter advances.
  always_comb begin
    cnt_inc  = cnt_q + CNT_W'(1);
    sync_bit = 1'b0;
    pay_bit  = 1'b0;
    for (int unsigned i = 0; i < SYNC_WIDTH; i++) begin
      if (cnt_inc == CNT_W'(i)) sync_bit = SYNC_CODE[i];
    end
    for (int unsigned i = 0; i < PAYLOAD_WIDTH; i++) begin
      if (cnt_inc == CNT_W'(i)) pay_bit = shift_q[i];
    end
  end

  // Next-state and next-output logic; outputs are pre-computed so that
  // the registered value matches the state being entered.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    ready_d    = 1'b0;
    tx_data_d  = 1'b0;
    tx_valid_d = 1'b0;
    done_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        cnt_d   = '0;
        if (start_i) begin
          shift_d    = payload_i;
          state_d    = ST_SYNC;
          ready_d    = 1'b0;
          tx_data_d  = SYNC_CODE[0];
          tx_valid_d = 1'b1;
        end
      end

      ST_SYNC: begin
        tx_valid_d = 1'b1;
        if (cnt_q == SYNC_LAST) begin
          state_d   = ST_PAYLOAD;
          cnt_d     = '0;
          tx_data_d = shift_q[0];
        end else begin
          cnt_d     = cnt_inc;
          tx_data_d = sync_bit;
        end
      end

      ST_PAYLOAD: begin
        if (cnt_q == PAY_LAST) begin
          done_d = 1'b1;
          cnt_d  = '0;
          if (GAP_CYCLES == 0) begin
            state_d = ST_IDLE;
            ready_d = 1'b1;
          end else begin
            state_d = ST_GAP;
          end
        end else begin
          tx_valid_d = 1'b1;
          cnt_d      = cnt_inc;
          tx_data_d  = pay_bit;
        end
      end

      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          ready_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      // Unreachable encodings recover to the reset condition.
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        shift_d = '0;
        ready_d = 1'b1;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      ready_q    <= 1'b1;
      tx_data_q  <= 1'b0;
      tx_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      ready_q    <= ready_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      done_q     <= done_d;
    end
  end

  assign ready_o    = ready_q;
  assign tx_data_o  = tx_data_q;
  assign tx_valid_o = tx_valid_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_sync_frame_tx.sv
// Directed bench for sync_frame_tx: one default instance plus one short
// instance (3-bit sync 110, 1-bit payload, no gap).
module tb_sync_frame_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [7:0] payload = '0;
  logic       ready, tx_data, tx_valid, done;

  logic       start2 = 1'b0;
  logic [0:0] payload2 = '0;
  logic       ready2, tx_data2, tx_valid2, done2;

  int vectors     = 0;
  int miscompares = 0;
  int det_cnt     = 0;
  int det_pos     = -1;

  always #5 clk = ~clk;

  sync_frame_tx u_dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
    .payload_i  (payload),
    .ready_o    (ready),
    .tx_data_o  (tx_data),
    .tx_valid_o (tx_valid),
    .done_o     (done)
  );

  sync_frame_tx #(
    .SYNC_WIDTH    (3),
    .SYNC_CODE     (3'b110),
    .PAYLOAD_WIDTH (1),
    .GAP_CYCLES    (0)
  ) u_dut2 (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start2),
    .payload_i  (payload2),
    .ready_o    (ready2),
    .tx_data_o  (tx_data2),
    .tx_valid_o (tx_valid2),
    .done_o     (done2)
  );

  // Receive-side 1001 detector on the default instance's serial stream.
  logic [2:0] hist = '0;
  logic       det_flag;
  always @(posedge clk) begin
    if (tx_valid) hist <= {hist[1:0], tx_data};
    else          hist <= '0;
  end
  assign det_flag = tx_valid && ({hist, tx_data} == 4'b1001);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Flags packed as {ready, done, tx_valid, tx_data}.
  function automatic logic [3:0] flags();
    return {ready, done, tx_valid, tx_data};
  endfunction

  function automatic logic [3:0] flags2();
    return {ready2, done2, tx_valid2, tx_data2};
  endfunction

  // Accept one frame on the default instance and check all 15 cycles.
  // The payload input is scrambled right after acceptance.
  task automatic send_and_check(input string tag, input logic [7:0] pl, input logic [11:0] bits);
    det_cnt = 0;
    det_pos = -1;
    start   = 1'b1;
    payload = pl;
    tick();
    start   = 1'b0;
    payload = ~pl;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) tick();
      chk($sformatf("%s_bit%0d", tag, k), 32'(flags()), {28'd0, 3'b001, bits[k]});
      if (det_flag) begin
        det_cnt++;
        det_pos = k;
      end
    end
    tick();
    chk({tag, "_done"}, 32'(flags()), 32'b0100);
    tick();
    chk({tag, "_gap"}, 32'(flags()), 32'b0000);
    tick();
    chk({tag, "_ready"}, 32'(flags()), 32'b1000);
  endtask

  initial begin
    logic [11:0] f3c;
    logic [3:0]  e;
    int          p;

    // Reset state
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_dut", 32'(flags()), 32'b1000);
    chk("rst_dut2", 32'(flags2()), 32'b1000);
    #3 rst_n = 1'b1;
    tick();
    chk("idle_after_rst", 32'(flags()), 32'b1000);

    // Frame with A5: sync 1001 then 1,0,1,0,0,1,0,1
    send_and_check("a5", 8'hA5, {8'hA5, 4'b1001});

    // Held start with 3C: frames every 15 cycles, no extras
    f3c     = {8'h3C, 4'b1001};
    start   = 1'b1;
    payload = 8'h3C;
    for (int i = 0; i < 45; i++) begin
      tick();
      p = i % 15;
      if (p < 12)       e = {3'b001, f3c[p]};
      else if (p == 12) e = 4'b0100;
      else if (p == 13) e = 4'b0000;
      else              e = 4'b1000;
      chk($sformatf("held_c%0d", i), 32'(flags()), 32'(e));
    end
    start = 1'b0;
    tick();
    chk("held_release_idle", 32'(flags()), 32'b1000);

    // 00 payload, input changed to FF after acceptance; detector check
    send_and_check("p00", 8'h00, {8'h00, 4'b1001});
    chk("det_count", 32'(det_cnt), 32'd1);
    chk("det_pos", 32'(det_pos), 32'd3);

    // Async reset mid-frame after T+6 (payload bit 2 of 96 is 1)
    start   = 1'b1;
    payload = 8'h96;
    tick();
    start   = 1'b0;
    payload = 8'h00;
    repeat (6) tick();
    chk("pre_rst_bit", 32'(flags()), 32'b0011);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async", 32'(flags()), 32'b1000);
    tick();
    chk("rst_hold", 32'(flags()), 32'b1000);
    #3 rst_n = 1'b1;
    tick();
    chk("rst_rel1", 32'(flags()), 32'b1000);
    tick();
    chk("rst_rel2", 32'(flags()), 32'b1000);
    send_and_check("post_rst", 8'h96, {8'h96, 4'b1001});

    // Short instance: sync 0,1,1 then payload, done+ready after T+4
    start2   = 1'b1;
    payload2 = 1'b1;
    tick();
    start2   = 1'b0;
    payload2 = 1'b0;
    chk("s_b0", 32'(flags2()), 32'b0010);
    tick();
    chk("s_b1", 32'(flags2()), 32'b0011);
    tick();
    chk("s_b2", 32'(flags2()), 32'b0011);
    tick();
    chk("s_pay1", 32'(flags2()), 32'b0011);
    tick();
    chk("s_done", 32'(flags2()), 32'b1100);
    start2   = 1'b1;
    payload2 = 1'b0;
    tick();
    start2   = 1'b0;
    payload2 = 1'b1;
    chk("s2_b0", 32'(flags2()), 32'b0010);
    repeat (3) tick();
    chk("s2_pay0", 32'(flags2()), 32'b0010);
    tick();
    chk("s2_done", 32'(flags2()), 32'b1100);
    tick();
    chk("s2_idle", 32'(flags2()), 32'b1000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sync_frame_tx.md
# sync_frame_tx

Serial frame transmitter that feeds the sync-code sequence detectors: on request it shifts out a fixed sync code, then a latched parallel payload, one bit per clock, LSB first. After the frame it holds the line idle for a programmable gap. It sits on the transmit side of the single-bit serial link and is the source whose output the link's sync detector locks onto.

## Interface
- SYNC_WIDTH, 4, number of sync-code bits (≥1)
- SYNC_CODE, 4'b1001, sync pattern; bit 0 transmitted first
- PAYLOAD_WIDTH, 8, payload bits per frame (≥1)
- GAP_CYCLES, 2, idle cycles after the last payload bit (≥0)

- clk  in  1  system clock; all state changes on posedge
- rst  in  1  reset; one clock domain, reset is asynchronous and active-low
- start  in  1  frame request, sampled on posedge only while ready=1
- payload  in  PAYLOAD_WIDTH  frame data, captured on the accepting edge
- ready  out  1  high only in IDLE; a start is accepted when ready=1
- tx_data  out  1  serial bit; 0 whenever tx_valid=0
- tx_valid  out  1  high while a sync or payload bit is on tx_data
- done  out  1  one-cycle pulse marking the end of the payload

## Operation
- All outputs registered. Reset values: ready=1, tx_data=0, tx_valid=0, done=0, state=IDLE, counters=0, shift register=0.
- States: IDLE, SYNC, PAYLOAD, GAP.
- IDLE: ready=1. If start=1 at an edge, capture payload into the shift register, set bit counter=0, and go to SYNC. Drive tx_data=SYNC_CODE[0] and tx_valid=1.
- SYNC: tx_data=SYNC_CODE[cnt]. After bit SYNC_WIDTH-1, go to PAYLOAD with cnt=0 and tx_data=payload[0].
- PAYLOAD: tx_data=shift[cnt], LSB first. After bit PAYLOAD_WIDTH-1:
  - go to GAP with done=1, tx_valid=0, tx_data=0, or
  - if GAP_CYCLES=0, go to IDLE with done=1 and ready=1.
- GAP: tx_valid=0, tx_data=0, ready=0 for GAP_CYCLES cycles, then go to IDLE. done is high only in the first cycle after the payload.
- start while ready=0 is ignored. It is not queued.
- Changes on payload after acceptance have no effect on the frame in flight.
- Counter width is clog2 of max(SYNC_WIDTH, PAYLOAD_WIDTH, GAP_CYCLES, 2). The counter never wraps inside a state. It reloads to 0 on every state change.
- Illegal or unreachable state encoding returns to IDLE with reset output values.
- Async reset mid-frame clears all outputs at once. The frame is abandoned and no done is issued.

## Timing
- Start accepted at edge T. Sync bit k is valid after edge T+k, for k=0..SYNC_WIDTH-1.
- Payload bit j is valid after edge T+SYNC_WIDTH+j.
- done and tx_valid=0 take effect after edge T+SYNC_WIDTH+PAYLOAD_WIDTH.
- ready returns to 1 after edge T+SYNC_WIDTH+PAYLOAD_WIDTH+GAP_CYCLES. The earliest next accepting edge is one cycle later.
- Frame pitch at back-to-back start is SYNC_WIDTH+PAYLOAD_WIDTH+GAP_CYCLES+1 cycles. With defaults this is 15.
- tx_valid is continuously high for exactly SYNC_WIDTH+PAYLOAD_WIDTH cycles per frame. With defaults this is 12.

## Test plan
- Reset, then start=1 with payload=8'hA5 at edge T. Required:
  - tx_data sequence after T..T+11 is 1,0,0,1 then 1,0,1,0,0,1,0,1, with tx_valid=1 throughout;
  - done=1 only after T+12;
  - ready=1 after T+14.
- Hold start=1 continuously with payload=8'h3C. Frames repeat every 15 cycles, each showing 1001 then 0,0,1,1,1,1,0,0. Starts asserted during busy produce no extra frames.
- Change payload to 8'hFF one cycle after acceptance of 8'h00. All 8 payload bits transmitted are 0.
- Assert rst low after edge T+6. Required:
  - tx_valid=0, tx_data=0, ready=1 and done=0 immediately, before the next clock;
  - a new start after release produces a complete, correct frame.
- With GAP_CYCLES=0, SYNC_WIDTH=3, SYNC_CODE=3'b110, PAYLOAD_WIDTH=1:
  - a start yields tx_data 0,1,1,payload with tx_valid=1;
  - done and ready are both 1 after edge T+4.
- Loop the output into the team's 1001 sync detector, default parameters, payload=8'h00. The detector flags exactly once per frame, aligned to the sync code.
